// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI flash read controller.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        SHIFT,
        STOP,
        DONE
    } spi_state_t;

    localparam logic [7:0] READ_CMD   = 8'h03;
    localparam int         FRAME_BITS = 64;

    // First received byte lands in the least significant byte.
    function automatic logic [31:0] le_pack(input logic [31:0] rx);
        return {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator for the SPI serial clock.
module spi_clk_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int W = $clog2(DIV);

    logic [W-1:0] cnt;

    assign tick = (cnt == W'(DIV - 1));

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/spi_flash_ctrl.sv
// SPI mode-0 flash controller issuing a 0x03 read and returning one
// little-endian 32-bit word per request.
module spi_flash_ctrl
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        spi_enable,
    input  logic [23:0] spi_addr,
    output logic [31:0] spi_data,
    output logic        spi_ack,
    output logic        busy,
    output logic        spi_sclk,
    output logic        spi_cs_n,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    spi_state_t  state;
    logic [31:0] tx;
    logic [31:0] rx;
    logic [6:0]  bit_cnt;
    logic        tick;

    assign busy = (state != IDLE);

    spi_clk_div #(
        .DIV(CLK_DIV)
    ) u_div (
        .clk  (clk),
        .reset(reset),
        .clear(state == IDLE),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            spi_cs_n <= 1'b1;
            spi_sclk <= 1'b0;
            spi_mosi <= 1'b0;
            spi_ack  <= 1'b0;
            spi_data <= '0;
            tx       <= '0;
            rx       <= '0;
            bit_cnt  <= '0;
        end else begin
            // Registered ack trails DONE by one cycle, giving a pulse
            // even when the requester already let go of spi_enable.
            spi_ack <= (state == DONE);
            unique case (state)
                IDLE: begin
                    if (spi_enable) begin
                        tx       <= {READ_CMD, spi_addr};
                        spi_mosi <= READ_CMD[7];
                        spi_cs_n <= 1'b0;
                        state    <= START;
                    end
                end
                START: begin
                    if (tick) state <= SHIFT;
                end
                SHIFT: begin
                    if (tick) begin
                        if (!spi_sclk) begin
                            spi_sclk <= 1'b1;
                            rx       <= {rx[30:0], spi_miso};
                        end else begin
                            spi_sclk <= 1'b0;
                            tx       <= {tx[30:0], 1'b0};
                            spi_mosi <= tx[30];
                            bit_cnt  <= bit_cnt + 7'd1;
                            if (bit_cnt + 7'd1 == 7'(FRAME_BITS)) begin
                                bit_cnt  <= '0;
                                spi_cs_n <= 1'b1;
                                spi_mosi <= 1'b0;
                                spi_data <= le_pack(rx);
                                state    <= STOP;
                            end
                        end
                    end
                end
                STOP: begin
                    if (tick) state <= DONE;
                end
                DONE: begin
                    if (!spi_enable) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_ctrl.sv
// Self-checking bench: table-driven reads against a flash model,
// plus enable-drop, mid-frame reset, back-to-back and CLK_DIV=255 cases.
module tb_spi_flash_ctrl;

    localparam int D  = 2;
    localparam int DB = 255;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        en;
    logic [23:0] addr;
    logic [31:0] data;
    logic        ack, busy, sclk, cs_n, mosi, miso;

    logic        en_b;
    logic [23:0] addr_b;
    logic [31:0] data_b;
    logic        ack_b, busy_b, sclk_b, cs_n_b, mosi_b, miso_b;

    int vectors = 0;
    int errors  = 0;

    spi_flash_ctrl #(.CLK_DIV(D)) dut (
        .clk(clk), .reset(reset), .spi_enable(en), .spi_addr(addr),
        .spi_data(data), .spi_ack(ack), .busy(busy), .spi_sclk(sclk),
        .spi_cs_n(cs_n), .spi_mosi(mosi), .spi_miso(miso)
    );

    spi_flash_ctrl #(.CLK_DIV(DB)) dut_big (
        .clk(clk), .reset(reset), .spi_enable(en_b), .spi_addr(addr_b),
        .spi_data(data_b), .spi_ack(ack_b), .busy(busy_b), .spi_sclk(sclk_b),
        .spi_cs_n(cs_n_b), .spi_mosi(mosi_b), .spi_miso(miso_b)
    );

    // Flash model: drives bit i of resp64 (MSB first) during SCLK period i.
    logic [63:0] resp64 = '0;
    int          fbit   = 0;
    always @(negedge cs_n) begin
        fbit = 0;
        miso = resp64[63];
    end
    always @(negedge sclk) begin
        if (cs_n === 1'b0) begin
            fbit++;
            if (fbit < 64) miso = resp64[63 - fbit];
        end
    end

    // MOSI capture and SCLK edge count.
    logic [63:0] cap;
    int          rises;
    int          rises_b;
    always @(posedge sclk) begin
        cap   = {cap[62:0], mosi};
        rises = rises + 1;
    end
    always @(posedge sclk_b) rises_b = rises_b + 1;

    // SCLK phase-length monitor while chip select is low.
    int   nruns, phase_bad, run;
    bit   in_frame = 1'b0;
    logic prev_sclk;
    function automatic void close_run();
        int exp_len;
        exp_len = (nruns == 0) ? 2 * D : D;
        if (run != exp_len) phase_bad++;
        nruns++;
    endfunction
    always @(negedge clk) begin
        if (cs_n === 1'b0) begin
            if (!in_frame) begin
                in_frame  = 1'b1;
                run       = 1;
                prev_sclk = sclk;
            end else if (sclk == prev_sclk) begin
                run++;
            end else begin
                close_run();
                prev_sclk = sclk;
                run       = 1;
            end
        end else if (in_frame) begin
            close_run();
            in_frame = 1'b0;
        end
    end

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: bytes arrive in order resp[31:24], [23:16], [15:8], [7:0].
    function automatic logic [31:0] model_data(input logic [31:0] r);
        logic [31:0] b0, b1, b2, b3;
        b0 = (r / 32'h0100_0000) % 256;
        b1 = (r / 32'h0001_0000) % 256;
        b2 = (r / 32'h0000_0100) % 256;
        b3 = r % 256;
        return b0 + b1 * 256 + b2 * 65536 + b3 * 16777216;
    endfunction

    task automatic run_frame(input logic [23:0] a, input logic [31:0] r,
                             input int drop_at, input bit gap_only,
                             output int lat, output int width,
                             output logic [31:0] dat, output logic bsy);
        resp64    = {32'hA5C3_5A3C, r};
        cap       = '0;
        rises     = 0;
        nruns     = 0;
        phase_bad = 0;
        @(negedge clk);
        en   = 1'b1;
        addr = a;
        @(posedge clk);
        lat   = 0;
        width = 0;
        while (lat < 140 * D) begin
            @(posedge clk);
            lat++;
            #1;
            if (ack) break;
            if (lat == drop_at) en = 1'b0;
        end
        if (!ack) lat = -1;
        dat = data;
        bsy = busy;
        @(negedge clk);
        en = 1'b0;
        if (!gap_only) begin
            width = 1;
            repeat (4) begin
                @(posedge clk);
                #1;
                if (ack) width++;
                else break;
            end
        end
    endtask

    typedef struct {
        logic [23:0] addr;
        logic [31:0] resp;
        logic [31:0] exp_data;
        logic [31:0] exp_cmd;
        int          exp_lat;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int          lat, width, lat2, width2;
        logic [31:0] dat, dat2, r1, r2;
        logic        bsy, bsy2;

        vecs[0] = '{24'h000100, 32'hDEADBEEF, 32'hEFBEADDE, 32'h03000100, 261};
        vecs[1] = '{24'hFFFFFF, 32'h0123_4567, 32'h6745_2301, 32'h03FFFFFF, 261};
        for (int i = 2; i < 6; i++) begin
            vecs[i].addr     = 24'($urandom);
            vecs[i].resp     = $urandom;
            vecs[i].exp_data = model_data(vecs[i].resp);
            vecs[i].exp_cmd  = {8'h03, vecs[i].addr};
            vecs[i].exp_lat  = 130 * D + 1;
        end

        reset  = 1'b0;
        en     = 1'b0;
        addr   = '0;
        en_b   = 1'b0;
        addr_b = '0;
        miso_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs_n", 64'(cs_n), 64'd1);
        check("rst_sclk", 64'(sclk), 64'd0);
        check("rst_mosi", 64'(mosi), 64'd0);
        check("rst_ack",  64'(ack),  64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_data", 64'(data), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i].addr, vecs[i].resp, -1, 1'b0,
                      lat, width, dat, bsy);
            check("vec_data",    64'(dat), 64'(vecs[i].exp_data));
            check("vec_mosi_hi", 64'(cap[63:32]), 64'(vecs[i].exp_cmd));
            check("vec_mosi_lo", 64'(cap[31:0]), 64'd0);
            check("vec_latency", 64'(lat), 64'(vecs[i].exp_lat));
            check("vec_rises",   64'(rises), 64'd64);
            check("vec_phases",  64'(nruns), 64'd128);
            check("vec_phase_len_bad", 64'(phase_bad), 64'd0);
            check("vec_ack_min_width", 64'(width >= 1), 64'd1);
            check("vec_idle_after", 64'(busy), 64'd0);
        end

        // Enable dropped mid-frame: frame completes, ack is a single pulse.
        r1 = $urandom;
        run_frame(24'($urandom), r1, 50, 1'b0, lat, width, dat, bsy);
        check("drop_data",    64'(dat), 64'(model_data(r1)));
        check("drop_latency", 64'(lat), 64'(130 * D + 1));
        check("drop_ack_width", 64'(width), 64'd1);
        check("drop_idle_at_ack", 64'(bsy), 64'd0);

        // Reset in the middle of a frame.
        @(negedge clk);
        en   = 1'b1;
        addr = 24'h123456;
        repeat (100) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        en    = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_cs_n", 64'(cs_n), 64'd1);
        check("midrst_sclk", 64'(sclk), 64'd0);
        check("midrst_ack",  64'(ack),  64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        r1 = $urandom;
        run_frame(24'h00ABCD, r1, -1, 1'b0, lat, width, dat, bsy);
        check("postrst_data",    64'(dat), 64'(model_data(r1)));
        check("postrst_latency", 64'(lat), 64'(130 * D + 1));
        check("postrst_rises",   64'(rises), 64'd64);

        // Back-to-back requests with a single low cycle in between.
        r1 = $urandom;
        r2 = $urandom;
        run_frame(24'h000000, r1, -1, 1'b1, lat, width, dat, bsy);
        run_frame(24'hFFFFFC, r2, -1, 1'b0, lat2, width2, dat2, bsy2);
        check("b2b_first_data",   64'(dat), 64'(model_data(r1)));
        check("b2b_first_lat",    64'(lat), 64'(130 * D + 1));
        check("b2b_second_data",  64'(dat2), 64'(model_data(r2)));
        check("b2b_second_lat",   64'(lat2), 64'(130 * D + 1));
        check("b2b_second_cmd",   64'(cap[63:32]), 64'h03FFFFFC);

        // Slowest divider: long frame without counter overflow.
        rises_b = 0;
        @(negedge clk);
        en_b   = 1'b1;
        addr_b = 24'($urandom);
        @(posedge clk);
        lat = 0;
        while (lat < 34000) begin
            @(posedge clk);
            lat++;
            #1;
            if (ack_b) break;
        end
        if (!ack_b) lat = -1;
        check("big_latency", 64'(lat), 64'(130 * DB + 1));
        check("big_data",    64'(data_b), 64'hFFFFFFFF);
        check("big_rises",   64'(rises_b), 64'd64);
        @(negedge clk);
        en_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("big_idle_after", 64'(busy_b), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
